// File: rtl/sigdel_pkg.sv
// Shared types and constants for the time-multiplexed sigma-delta scheduler.
// The LFSR items are only used when SIGDEL_DITHER_EN is defined.
package sigdel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } sched_state_t;

  // Feedback levels of the 1-bit DAC for a W-bit two's complement sample.
  function automatic logic signed [63:0] full_pos(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] full_neg(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Fibonacci form: taps at bits 0, 2, 3, 5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/sigdel_channel_scheduler_if.sv
// Sample write port of the scheduler: valid/ready handshake carrying a channel index and a signed sample.
interface sigdel_channel_scheduler_if #(
  parameter int input_bitwidth = 24,
  parameter int ch_idx_width   = 2
);

  logic                             in_valid;
  logic                             in_ready;
  logic        [ch_idx_width-1:0]   in_channel;
  logic signed [input_bitwidth-1:0] in_data;

  modport master (
    output in_valid,
    output in_channel,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_channel,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/sigdel_update_core.sv
// Combinational first-order sigma-delta step for one channel: decides the output bit from the
// integrator sign and returns the integrator advanced by (sample - feedback + dither).
module sigdel_update_core
  import sigdel_pkg::*;
#(
  parameter int input_bitwidth = 24
) (
  input  logic signed [input_bitwidth+1:0] integ,
  input  logic signed [input_bitwidth-1:0] sample,
  input  logic                             dither,
  output logic signed [input_bitwidth+1:0] integ_next,
  output logic                             out_bit
);

  localparam int W = input_bitwidth;
  localparam logic signed [W-1:0] FULL_POS = W'(full_pos(W));
  localparam logic signed [W-1:0] FULL_NEG = W'(full_neg(W));

  logic signed [W-1:0] fb;
  logic signed [W:0]   err;
  logic signed [W+1:0] err_dith;

  // NOTE: every output and temporary is assigned on every pass, so no latch can be inferred.
  always_comb begin
    out_bit    = ~integ[W+1];
    fb         = out_bit ? FULL_POS : FULL_NEG;
    err        = {sample[W-1], sample} - {fb[W-1], fb};
    // Widened before the dither add so the +1 on the largest error cannot overflow.
    err_dith   = {err[W], err} + {{(W+1){1'b0}}, dither};
    integ_next = integ + err_dith;
  end

endmodule

// File: rtl/sigdel_channel_scheduler.sv
// Round-robin scheduler sharing one sigma-delta update datapath across num_channels channels.
// Define SIGDEL_DITHER_EN to add a 16-bit LFSR dither bit to each update's error term.
module sigdel_channel_scheduler
  import sigdel_pkg::*;
#(
  parameter int input_bitwidth = 24,
  parameter int num_channels   = 4,
  parameter int ch_idx_width   = 2
) (
  input  logic                      mod_clock,
  input  logic                      mod_reset,
  sigdel_channel_scheduler_if.slave wr,
  input  logic                      run,
  input  logic                      clear,
  output logic [num_channels-1:0]   out_bits,
  output logic                      out_strobe,
  output logic [ch_idx_width-1:0]   slot,
  output logic                      busy
);

  localparam int W = input_bitwidth;
  localparam logic [ch_idx_width-1:0] LAST_SLOT = ch_idx_width'(num_channels - 1);

  sched_state_t      state;
  logic              ready_q;
  logic signed [W-1:0] sample_mem [num_channels];
  logic signed [W+1:0] integ_mem  [num_channels];

  logic                wr_fire;
  logic                dither;
  logic                upd_bit;
  logic signed [W+1:0] integ_next;

  assign wr.in_ready = ready_q;
  assign wr_fire     = wr.in_valid && ready_q;

`ifdef SIGDEL_DITHER_EN
  logic [15:0] lfsr;
  assign dither = lfsr[0];
`else
  assign dither = 1'b0;
`endif

  sigdel_update_core #(
    .input_bitwidth(W)
  ) u_core (
    .integ     (integ_mem[slot]),
    .sample    (sample_mem[slot]),
    .dither    (dither),
    .integ_next(integ_next),
    .out_bit   (upd_bit)
  );

  // NOTE: all state uses non-blocking assignments, so every read in this block sees the pre-edge
  // value; that is what lets a write to the slot being processed still use the old sample.
  always_ff @(posedge mod_clock) begin
    if (mod_reset) begin
      state      <= ST_IDLE;
      slot       <= '0;
      out_bits   <= '0;
      out_strobe <= 1'b0;
      busy       <= 1'b0;
      ready_q    <= 1'b0;
      // NOTE: the per-channel arrays are small register files that must come up zeroed,
      // so they are reset here rather than left to power-up contents.
      for (int c = 0; c < num_channels; c++) begin
        sample_mem[c] <= '0;
        integ_mem[c]  <= '0;
      end
`ifdef SIGDEL_DITHER_EN
      lfsr <= LFSR_SEED;
`endif
    end else begin
      ready_q    <= 1'b1;
      out_strobe <= 1'b0;

      // Indices at or above num_channels are accepted and dropped.
      if (wr_fire && (int'(wr.in_channel) < num_channels)) begin
        sample_mem[wr.in_channel] <= wr.in_data;
      end

      case (state)
        ST_IDLE: begin
          if (clear) begin
            state <= ST_CLEAR;
            slot  <= '0;
            busy  <= 1'b1;
          end else if (run) begin
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (clear) begin
            state <= ST_CLEAR;
            slot  <= '0;
            busy  <= 1'b1;
          end else if (!run) begin
            state <= ST_IDLE;
          end else begin
            integ_mem[slot] <= integ_next;
            out_bits[slot]  <= upd_bit;
            out_strobe      <= (slot == LAST_SLOT);
            slot            <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
`ifdef SIGDEL_DITHER_EN
            lfsr <= lfsr_next(lfsr);
`endif
          end
        end

        ST_CLEAR: begin
          // One integrator per cycle; a clear pulse arriving here is ignored.
          integ_mem[slot] <= '0;
          if (slot == LAST_SLOT) begin
            slot  <= '0;
            busy  <= 1'b0;
            state <= run ? ST_RUN : ST_IDLE;
          end else begin
            slot <= slot + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          slot  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sigdel_channel_scheduler.sv
// Scoreboard bench: two schedulers (4 and 3 channels) share stimulus; a spec-level model predicts
// every cycle's outputs into queues that a separate monitor drains and compares.
module tb_sigdel_channel_scheduler;

  localparam int W  = 24;
  localparam int CW = 2;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_CLEAR = 2;

  logic mod_clock = 1'b0;
  logic mod_reset;
  logic run;
  logic clear;

  always #5 mod_clock = ~mod_clock;

  sigdel_channel_scheduler_if #(.input_bitwidth(W), .ch_idx_width(CW)) wr4 ();
  sigdel_channel_scheduler_if #(.input_bitwidth(W), .ch_idx_width(CW)) wr3 ();

  logic [3:0]    out_bits4;
  logic [2:0]    out_bits3;
  logic          out_strobe4, out_strobe3;
  logic [CW-1:0] slot4, slot3;
  logic          busy4, busy3;

  sigdel_channel_scheduler #(.input_bitwidth(W), .num_channels(4), .ch_idx_width(CW)) dut4 (
    .mod_clock (mod_clock),
    .mod_reset (mod_reset),
    .wr        (wr4),
    .run       (run),
    .clear     (clear),
    .out_bits  (out_bits4),
    .out_strobe(out_strobe4),
    .slot      (slot4),
    .busy      (busy4)
  );

  sigdel_channel_scheduler #(.input_bitwidth(W), .num_channels(3), .ch_idx_width(CW)) dut3 (
    .mod_clock (mod_clock),
    .mod_reset (mod_reset),
    .wr        (wr3),
    .run       (run),
    .clear     (clear),
    .out_bits  (out_bits3),
    .out_strobe(out_strobe3),
    .slot      (slot3),
    .busy      (busy3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (index 0: 4 channels, index 1: 3 channels) ----------------
  typedef struct {
    logic [3:0] bits;
    logic       strobe;
    logic [1:0] slot;
    logic       busy;
    logic       ready;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int          nch [2] = '{4, 3};
  longint      m_integ  [2][4];
  longint      m_sample [2][4];
  bit          m_bits   [2][4];
  int          m_mode   [2];
  int          m_slot   [2];
  bit          m_ready  [2];
  bit          m_strobe [2];
  logic [15:0] m_lfsr   [2];

  // Integrator arithmetic is modulo 2^(W+2), interpreted as signed.
  function automatic longint wrap(input longint v);
    longint m;
    m = v & ((64'sd1 <<< (W + 2)) - 1);
    if (m >= (64'sd1 <<< (W + 1))) m = m - (64'sd1 <<< (W + 2));
    return m;
  endfunction

  task automatic model_step(input int d, input bit rst, input bit r, input bit c,
                            input bit v, input int ch, input logic [W-1:0] data);
    bit     upd, wr_ok, b;
    longint fb, dith;
    int     s;
    logic signed [W-1:0] sd;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_integ[d][k] = 0; m_sample[d][k] = 0; m_bits[d][k] = 0;
      end
      m_mode[d] = M_IDLE; m_slot[d] = 0; m_ready[d] = 0; m_strobe[d] = 0;
      m_lfsr[d] = 16'hACE1;
      return;
    end
    upd   = (m_mode[d] == M_RUN) && r && !c;
    wr_ok = v && m_ready[d] && (ch < nch[d]);
    m_strobe[d] = 0;
    if (upd) begin
      s    = m_slot[d];
      b    = (m_integ[d][s] >= 0);
      fb   = b ? ((64'sd1 <<< (W - 1)) - 1) : -(64'sd1 <<< (W - 1));
      dith = 0;
`ifdef SIGDEL_DITHER_EN
      dith = m_lfsr[d][0];
      m_lfsr[d] = {m_lfsr[d][0] ^ m_lfsr[d][2] ^ m_lfsr[d][3] ^ m_lfsr[d][5], m_lfsr[d][15:1]};
`endif
      m_integ[d][s] = wrap(m_integ[d][s] + m_sample[d][s] - fb + dith);
      m_bits[d][s]  = b;
      m_strobe[d]   = (s == nch[d] - 1);
      m_slot[d]     = (s + 1) % nch[d];
    end
    case (m_mode[d])
      M_IDLE: begin
        if (c) begin m_mode[d] = M_CLEAR; m_slot[d] = 0; end
        else if (r) m_mode[d] = M_RUN;
      end
      M_RUN: begin
        if (c) begin m_mode[d] = M_CLEAR; m_slot[d] = 0; end
        else if (!r) m_mode[d] = M_IDLE;
      end
      default: begin
        m_integ[d][m_slot[d]] = 0;
        if (m_slot[d] == nch[d] - 1) begin
          m_slot[d] = 0;
          m_mode[d] = r ? M_RUN : M_IDLE;
        end else begin
          m_slot[d]++;
        end
      end
    endcase
    if (wr_ok) begin
      sd = data;
      m_sample[d][ch] = sd;
    end
    m_ready[d] = 1;
  endtask

  // Applies inputs for the next rising edge and queues the outputs the model predicts after it.
  task automatic drive(input bit rst, input bit r, input bit c, input bit v,
                       input int ch, input logic [W-1:0] data);
    exp_t e;
    @(negedge mod_clock);
    mod_reset = rst; run = r; clear = c;
    wr4.in_valid = v; wr4.in_channel = ch[1:0]; wr4.in_data = data;
    wr3.in_valid = v; wr3.in_channel = ch[1:0]; wr3.in_data = data;
    for (int d = 0; d < 2; d++) begin
      model_step(d, rst, r, c, v, ch, data);
      e.bits = '0;
      for (int k = 0; k < nch[d]; k++) e.bits[k] = m_bits[d][k];
      e.strobe = m_strobe[d];
      e.slot   = 2'(m_slot[d]);
      e.busy   = (m_mode[d] == M_CLEAR);
      e.ready  = m_ready[d];
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge mod_clock);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("n4 out_bits",   32'(out_bits4),   32'(e.bits));
        check("n4 out_strobe", 32'(out_strobe4), 32'(e.strobe));
        check("n4 slot",       32'(slot4),       32'(e.slot));
        check("n4 busy",       32'(busy4),       32'(e.busy));
        check("n4 in_ready",   32'(wr4.in_ready), 32'(e.ready));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("n3 out_bits",   32'({1'b0, out_bits3}), 32'(e.bits));
        check("n3 out_strobe", 32'(out_strobe3), 32'(e.strobe));
        check("n3 slot",       32'(slot3),       32'(e.slot));
        check("n3 busy",       32'(busy3),       32'(e.busy));
        check("n3 in_ready",   32'(wr3.in_ready), 32'(e.ready));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ones, frames, wait_cyc;
    bit r, c, v;
    mod_reset = 1'b1; run = 1'b0; clear = 1'b0;
    wr4.in_valid = 1'b0; wr4.in_channel = '0; wr4.in_data = '0;
    wr3.in_valid = 1'b0; wr3.in_channel = '0; wr3.in_data = '0;

    repeat (2) drive(1, 0, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0);

    // Zero input: every channel toggles 1,0 frame by frame.
    repeat (24) drive(0, 1, 0, 0, 0, 0);

    // run drop: slot held, no strobe; then resume from the held slot.
    repeat (2) drive(0, 1, 0, 0, 0, 0);
    repeat (5) drive(0, 0, 0, 0, 0, 0);
    repeat (6) drive(0, 1, 0, 0, 0, 0);

    // Static samples loaded while idle, then a clear before measuring density.
    drive(0, 0, 0, 1, 2, 24'h7FFFFF);
    drive(0, 0, 0, 1, 1, 24'h800000);
    drive(0, 0, 0, 1, 0, 24'h400000);
    drive(0, 0, 0, 1, 3, 24'h123456);
    drive(0, 1, 1, 0, 0, 0);
    ones = 0; frames = 0;
    for (int i = 0; i < 400 && frames < 64; i++) begin
      drive(0, 1, 0, 0, 0, 0);
      if (out_strobe4 === 1'b1) begin
        frames++;
        if (out_bits4[0] === 1'b1) ones++;
      end
    end
    check("n4 density frames", 32'(frames), 32'd64);
    n_checks++;
    if (ones < 47 || ones > 49) begin
      n_errors++;
      $display("FAIL n4 ch0 density: got %0d ones expected 48+-1", ones);
    end

    // Write to the slot being processed in the very same cycle.
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 1, m_slot[0], 24'(i * 24'h0F0F0F));

    // Clear mid-frame while running, plus a clear pulse inside CLEAR.
    repeat (2) drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    repeat (12) drive(0, 1, 0, 0, 0, 0);
    // Clear ending with run low.
    drive(0, 0, 1, 0, 0, 0);
    repeat (6) drive(0, 0, 0, 0, 0, 0);

    // Reset in the middle of a frame and in the middle of CLEAR.
    repeat (3) drive(0, 1, 0, 1, 1, 24'h00ABCD);
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    repeat (2) drive(0, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);

    // Randomised traffic, including out-of-range channels for the 3-channel instance.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 63) == 0);
      v = ($urandom_range(0, 2) == 0);
      drive(($urandom_range(0, 999) == 0), r, c, v, $urandom_range(0, 3), 24'($urandom));
    end

    // Long zero-input run from reset (exercises the dither sequence when enabled).
    drive(1, 0, 0, 0, 0, 0);
    repeat (4000) drive(0, 1, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0);

    wait_cyc = 0;
    while ((q0.size() > 0 || q1.size() > 0) && wait_cyc < 10) begin
      @(posedge mod_clock);
      wait_cyc++;
    end
    #3;
    n_checks++;
    if (q0.size() > 0 || q1.size() > 0) begin
      n_errors++;
      $display("FAIL scoreboard drain: got %0d/%0d pending expected 0", q0.size(), q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
